// File: rtl/pmod_byte_receiver.sv
// rtl/pmod_byte_receiver.sv - single-wire PMOD byte link receiver with hex 7-segment display
module pmod_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_PMOD_1,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Frame_Err,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2
);

    localparam logic [7:0] MID  = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic [6:0] seg1_q, seg1_d;
    logic [6:0] seg2_q, seg2_d;
    logic       rx;

    assign rx = sync2_q;

    always_comb begin
        state_d     = state_q;
        sync1_d     = i_PMOD_1;
        sync2_d     = sync1_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = frame_err_q;
        seg1_d      = seg1_q;
        seg2_d      = seg2_q;

        case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d   = START;
                    clk_cnt_d = 8'd0;
                end
            end
            START: begin
                if (clk_cnt_q == MID) begin
                    clk_cnt_d = 8'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d          = 8'd0;
                    shift_d[bit_idx_q] = rx;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = 8'd0;
                    if (rx) begin
                        data_d      = shift_q;
                        valid_d     = 1'b1;
                        frame_err_d = 1'b0;
                        seg1_d      = hex_to_seg(shift_q[7:4]);
                        seg2_d      = hex_to_seg(shift_q[3:0]);
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            WAIT_IDLE: begin
                // A line stuck low must go high before another start edge is accepted.
                if (rx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            clk_cnt_q   <= 8'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            seg1_q      <= 7'h40;
            seg2_q      <= 7'h40;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            seg1_q      <= seg1_d;
            seg2_q      <= seg2_d;
        end
    end

    assign o_Data      = data_q;
    assign o_Valid     = valid_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Segment1  = seg1_q;
    assign o_Segment2  = seg2_q;

endmodule

// File: tb/tb_pmod_byte_receiver.sv
// tb/tb_pmod_byte_receiver.sv - directed self-checking bench for pmod_byte_receiver
module tb_pmod_byte_receiver;

    logic       clk;
    logic       rst;
    logic       line2, line4;
    logic [7:0] data2, data4;
    logic       valid2, valid4;
    logic       err2, err4;
    logic [6:0] seg1_2, seg2_2, seg1_4, seg2_4;

    int checks = 0;
    int errors = 0;

    int         vcnt2 = 0;
    int         vcnt4 = 0;
    logic [7:0] last2 = 8'h00;
    logic [7:0] prev2 = 8'h00;
    logic [7:0] last4 = 8'h00;

    pmod_byte_receiver #(.CLKS_PER_BIT(2)) dut2 (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_PMOD_1   (line2),
        .o_Data     (data2),
        .o_Valid    (valid2),
        .o_Frame_Err(err2),
        .o_Segment1 (seg1_2),
        .o_Segment2 (seg2_2)
    );

    pmod_byte_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_PMOD_1   (line4),
        .o_Data     (data4),
        .o_Valid    (valid4),
        .o_Frame_Err(err4),
        .o_Segment1 (seg1_4),
        .o_Segment2 (seg2_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle o_Valid is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (valid2 === 1'b1) begin
            vcnt2 = vcnt2 + 1;
            prev2 = last2;
            last2 = data2;
        end
        if (valid4 === 1'b1) begin
            vcnt4 = vcnt4 + 1;
            last4 = data4;
        end
    end

    task automatic drive_bit(input bit sel4, input logic b, input int cycles);
        if (sel4) line4 = b;
        else      line2 = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel4, input logic [7:0] d, input logic stop_b);
        int cpb;
        cpb = sel4 ? 4 : 2;
        drive_bit(sel4, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(sel4, d[i], cpb);
        drive_bit(sel4, stop_b, cpb);
    endtask

    task automatic test_reset;
        int c0;
        rst   = 1'b1;
        line2 = 1'b0;
        line4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data2 !== 8'h00)   begin errors++; $display("FAIL reset_data got %h expected 00", data2); end
        checks++; if (valid2 !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b expected 0", valid2); end
        checks++; if (err2 !== 1'b0)     begin errors++; $display("FAIL reset_err got %b expected 0", err2); end
        checks++; if (seg1_2 !== 7'h40)  begin errors++; $display("FAIL reset_seg1 got %h expected 40", seg1_2); end
        checks++; if (seg2_2 !== 7'h40)  begin errors++; $display("FAIL reset_seg2 got %h expected 40", seg2_2); end
        c0    = vcnt2;
        line2 = 1'b1;
        line4 = 1'b1;
        rst   = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (vcnt2 !== c0)      begin errors++; $display("FAIL reset_no_byte got %0d expected %0d", vcnt2, c0); end
        checks++; if (err2 !== 1'b0)     begin errors++; $display("FAIL reset_no_err got %b expected 0", err2); end
    endtask

    task automatic test_byte_a5;
        int c0;
        c0 = vcnt2;
        send_frame(1'b0, 8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (vcnt2 !== c0 + 1)  begin errors++; $display("FAIL a5_valid_count got %0d expected %0d", vcnt2, c0 + 1); end
        checks++; if (data2 !== 8'hA5)   begin errors++; $display("FAIL a5_data got %h expected a5", data2); end
        checks++; if (seg1_2 !== 7'h08)  begin errors++; $display("FAIL a5_seg1 got %h expected 08", seg1_2); end
        checks++; if (seg2_2 !== 7'h12)  begin errors++; $display("FAIL a5_seg2 got %h expected 12", seg2_2); end
        checks++; if (err2 !== 1'b0)     begin errors++; $display("FAIL a5_err got %b expected 0", err2); end
    endtask

    task automatic test_frame_error;
        int c0;
        c0 = vcnt2;
        send_frame(1'b0, 8'h3C, 1'b0);
        drive_bit(1'b0, 1'b0, 10);
        checks++; if (err2 !== 1'b1)     begin errors++; $display("FAIL ferr_flag got %b expected 1", err2); end
        checks++; if (vcnt2 !== c0)      begin errors++; $display("FAIL ferr_no_valid got %0d expected %0d", vcnt2, c0); end
        checks++; if (data2 !== 8'hA5)   begin errors++; $display("FAIL ferr_data_kept got %h expected a5", data2); end
        checks++; if (seg2_2 !== 7'h12)  begin errors++; $display("FAIL ferr_seg_kept got %h expected 12", seg2_2); end
        drive_bit(1'b0, 1'b1, 10);
        send_frame(1'b0, 8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (vcnt2 !== c0 + 1)  begin errors++; $display("FAIL ferr_recover_count got %0d expected %0d", vcnt2, c0 + 1); end
        checks++; if (data2 !== 8'h3C)   begin errors++; $display("FAIL ferr_recover_data got %h expected 3c", data2); end
        checks++; if (err2 !== 1'b0)     begin errors++; $display("FAIL ferr_cleared got %b expected 0", err2); end
        checks++; if (seg1_2 !== 7'h30)  begin errors++; $display("FAIL ferr_recover_seg1 got %h expected 30", seg1_2); end
        checks++; if (seg2_2 !== 7'h46)  begin errors++; $display("FAIL ferr_recover_seg2 got %h expected 46", seg2_2); end
    endtask

    task automatic test_glitch;
        int c0;
        c0 = vcnt4;
        drive_bit(1'b1, 1'b0, 1);
        drive_bit(1'b1, 1'b1, 40);
        checks++; if (vcnt4 !== c0)      begin errors++; $display("FAIL glitch_no_valid got %0d expected %0d", vcnt4, c0); end
        checks++; if (err4 !== 1'b0)     begin errors++; $display("FAIL glitch_no_err got %b expected 0", err4); end
        send_frame(1'b1, 8'h01, 1'b1);
        drive_bit(1'b1, 1'b1, 12);
        checks++; if (vcnt4 !== c0 + 1)  begin errors++; $display("FAIL glitch_next_count got %0d expected %0d", vcnt4, c0 + 1); end
        checks++; if (data4 !== 8'h01)   begin errors++; $display("FAIL glitch_next_data got %h expected 01", data4); end
        checks++; if (seg2_4 !== 7'h79)  begin errors++; $display("FAIL glitch_next_seg2 got %h expected 79", seg2_4); end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = vcnt2;
        send_frame(1'b0, 8'h00, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (vcnt2 !== c0 + 2)  begin errors++; $display("FAIL b2b_count got %0d expected %0d", vcnt2, c0 + 2); end
        checks++; if (prev2 !== 8'h00)   begin errors++; $display("FAIL b2b_first got %h expected 00", prev2); end
        checks++; if (last2 !== 8'hFF)   begin errors++; $display("FAIL b2b_second got %h expected ff", last2); end
        checks++; if (seg1_2 !== 7'h0E)  begin errors++; $display("FAIL b2b_seg1 got %h expected 0e", seg1_2); end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        logic [7:0] d;
        d  = 8'h12;
        c0 = vcnt2;
        drive_bit(1'b0, 1'b0, 2);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i], 2);
        line2 = d[4];
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        drive_bit(1'b0, 1'b1, 30);
        checks++; if (vcnt2 !== c0)      begin errors++; $display("FAIL rmid_no_valid got %0d expected %0d", vcnt2, c0); end
        checks++; if (data2 !== 8'h00)   begin errors++; $display("FAIL rmid_data got %h expected 00", data2); end
        checks++; if (err2 !== 1'b0)     begin errors++; $display("FAIL rmid_err got %b expected 0", err2); end
        checks++; if (seg1_2 !== 7'h40)  begin errors++; $display("FAIL rmid_seg1 got %h expected 40", seg1_2); end
        checks++; if (seg2_2 !== 7'h40)  begin errors++; $display("FAIL rmid_seg2 got %h expected 40", seg2_2); end
        send_frame(1'b0, 8'h12, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (vcnt2 !== c0 + 1)  begin errors++; $display("FAIL rmid_next_count got %0d expected %0d", vcnt2, c0 + 1); end
        checks++; if (data2 !== 8'h12)   begin errors++; $display("FAIL rmid_next_data got %h expected 12", data2); end
        checks++; if (seg1_2 !== 7'h79)  begin errors++; $display("FAIL rmid_next_seg1 got %h expected 79", seg1_2); end
        checks++; if (seg2_2 !== 7'h24)  begin errors++; $display("FAIL rmid_next_seg2 got %h expected 24", seg2_2); end
    endtask

    initial begin
        rst   = 1'b1;
        line2 = 1'b1;
        line4 = 1'b1;
        @(negedge clk);
        test_reset;
        test_byte_a5;
        test_frame_error;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
